// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command sequencer: command word layout,
// command codes, sequencer states and host register addresses.
package sprite_cmd_pkg;

    // Command word field positions
    localparam int SUBCOMP_MSB = 31;
    localparam int SUBCOMP_LSB = 26;
    localparam int CHILD_MSB   = 25;
    localparam int CHILD_LSB   = 21;
    localparam int INFO_MSB    = 20;
    localparam int INFO_LSB    = 17;
    localparam int TYPE_MSB    = 16;
    localparam int TYPE_LSB    = 14;
    localparam int PPSEL_BIT   = 13;
    localparam int MSG_MSB     = 12;
    localparam int MSG_LSB     = 0;

    // Command codes carried in the info field
    localparam logic [3:0] INFO_WRITE = 4'h1;
    localparam logic [3:0] INFO_FLUSH = 4'hF;

    // Host register map
    localparam logic [1:0] REG_DATA_STATUS = 2'd0;
    localparam logic [1:0] REG_CTRL_FRAME  = 2'd1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_VBLANK = 2'd2,
        COMMIT      = 2'd3
    } seq_state_t;

    function automatic logic [3:0] info_of(input logic [31:0] word);
        return word[INFO_MSB:INFO_LSB];
    endfunction

    function automatic logic [31:0] pack_cmd(
        input logic [5:0]  sub_comp,
        input logic [4:0]  child,
        input logic [3:0]  info,
        input logic [2:0]  kind,
        input logic        pp_sel,
        input logic [12:0] msg
    );
        logic [31:0] word;
        word = '0;
        word[SUBCOMP_MSB:SUBCOMP_LSB] = sub_comp;
        word[CHILD_MSB:CHILD_LSB]     = child;
        word[INFO_MSB:INFO_LSB]       = info;
        word[TYPE_MSB:TYPE_LSB]       = kind;
        word[PPSEL_BIT]               = pp_sel;
        word[MSG_MSB:MSG_LSB]         = msg;
        return word;
    endfunction

endpackage

// File: rtl/sprite_cmd_sequencer_if.sv
// Avalon-MM host port of the sprite command sequencer.
interface sprite_cmd_sequencer_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO for host command words.
// A push while full is ignored; the caller is expected to flag it.
module cmd_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sprite_cmd_sequencer.sv
// Sprite command sequencer: queues host command words, forwards sprite
// writes to the hidden ping-pong buffer, and holds frame commits until
// vertical blank so the buffer swap never tears mid-scan.
module sprite_cmd_sequencer
    import sprite_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int VBLANK_LINE = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    sprite_cmd_sequencer_if.slave host,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    output logic [31:0]           cmd_out,
    output logic                  front_buf,
    output logic                  irq
);

    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    seq_state_t         state;
    seq_state_t         state_next;
    logic [31:0]        cur_word;
    logic [31:0]        cmd_next;
    logic [31:0]        fifo_rdata;
    logic [LEVEL_W-1:0] fifo_level;
    logic [7:0]         level8;
    logic [1:0]         state_bits;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push;
    logic               ctrl_write;
    logic               commit_now;
    logic               in_vblank;
    logic               committed_this_blank;
    logic               overflow;
    logic [15:0]        frame_cnt;
    logic               unused_hcount;

    assign unused_hcount = ^hcount;
    assign push          = host.chipselect && host.write && (host.address == REG_DATA_STATUS);
    assign ctrl_write    = host.chipselect && host.write && (host.address == REG_CTRL_FRAME);
    assign in_vblank     = (vcount >= 10'(VBLANK_LINE));
    assign level8        = 8'(fifo_level);
    assign state_bits    = state;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (host.writedata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, FIFO pop and the command word to drive after this edge
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        cmd_next   = '0;
        commit_now = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (info_of(cur_word) == INFO_FLUSH) begin
                    state_next = WAIT_VBLANK;
                end else begin
                    if (info_of(cur_word) == INFO_WRITE) begin
                        cmd_next            = cur_word;
                        cmd_next[PPSEL_BIT] = ~front_buf;
                    end
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            WAIT_VBLANK: begin
                if (in_vblank && !committed_this_blank) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                cmd_next   = pack_cmd(6'd0, 5'd0, INFO_FLUSH, 3'd0, ~front_buf, 13'd0);
                commit_now = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command output, popped word and frame bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_out              <= '0;
            cur_word             <= '0;
            front_buf            <= 1'b0;
            committed_this_blank <= 1'b0;
            frame_cnt            <= '0;
            irq                  <= 1'b0;
            overflow             <= 1'b0;
        end else begin
            cmd_out <= cmd_next;
            if (pop) begin
                cur_word <= fifo_rdata;
            end
            if (commit_now) begin
                front_buf <= ~front_buf;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (!in_vblank) begin
                committed_this_blank <= 1'b0;
            end else if (commit_now) begin
                committed_this_blank <= 1'b1;
            end
            if (commit_now) begin
                irq <= 1'b1;
            end else if (ctrl_write && host.writedata[0]) begin
                irq <= 1'b0;
            end
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end else if (ctrl_write && host.writedata[1]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Registered host read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host.readdata <= '0;
        end else if (host.chipselect && host.read) begin
            case (host.address)
                REG_DATA_STATUS: host.readdata <= {overflow, front_buf, state_bits, 20'b0, level8};
                REG_CTRL_FRAME:  host.readdata <= {16'b0, frame_cnt};
                default:         host.readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_cmd_sequencer.sv
// Testbench for sprite_cmd_sequencer: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// transaction-level model of the command queue and frame commits.
module tb_sprite_cmd_sequencer;

    localparam int DEPTH = 64;
    localparam int VBL   = 480;
    localparam int FRAME = 525;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic [31:0] cmd_out;
    logic        front_buf;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    sprite_cmd_sequencer_if bus ();

    sprite_cmd_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .VBLANK_LINE (VBL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (bus),
        .hcount    (hcount),
        .vcount    (vcount),
        .cmd_out   (cmd_out),
        .front_buf (front_buf),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time commit spacing
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Raster position: one line per clock, shortly after each rising edge
    always begin
        @(posedge clk);
        #2;
        hcount = hcount + 10'd1;
        vcount = (vcount == 10'(FRAME - 1)) ? 10'd0 : vcount + 10'd1;
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_q[$];
    logic        m_exam   = 1'b0;
    logic        m_park   = 1'b0;
    logic        m_commit = 1'b0;
    logic        m_cb     = 1'b0;
    logic [31:0] m_word   = '0;
    logic        m_front  = 1'b0;
    logic        m_irq    = 1'b0;
    logic        m_ovf    = 1'b0;
    logic [15:0] m_frames = '0;
    logic [31:0] m_cmd    = '0;
    logic [31:0] m_rdata  = '0;

    task automatic model_reset();
        m_q.delete();
        m_exam = 1'b0; m_park = 1'b0; m_commit = 1'b0; m_cb = 1'b0;
        m_word = '0; m_front = 1'b0; m_irq = 1'b0; m_ovf = 1'b0;
        m_frames = '0; m_cmd = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        logic       vb;
        logic       is_flush;
        logic       do_pop;
        logic       n_exam, n_park, n_commit;
        logic [1:0] st;
        int         lvl;
        vb       = (vcount >= 10'(VBL));
        lvl      = m_q.size();
        st       = m_exam ? 2'd1 : m_park ? 2'd2 : m_commit ? 2'd3 : 2'd0;
        is_flush = m_exam && (m_word[20:17] == 4'hF);
        do_pop   = (st == 2'd0 || (m_exam && !is_flush)) && (lvl > 0);

        if (bus.chipselect && bus.read) begin
            if (bus.address == 2'd0)      m_rdata = {m_ovf, m_front, st, 20'b0, 8'(lvl)};
            else if (bus.address == 2'd1) m_rdata = {16'b0, m_frames};
            else                          m_rdata = '0;
        end

        if (m_exam && m_word[20:17] == 4'h1)
            m_cmd = m_front ? (m_word & ~32'h0000_2000) : (m_word | 32'h0000_2000);
        else if (m_commit)
            m_cmd = m_front ? 32'h001E_0000 : 32'h001E_2000;
        else
            m_cmd = '0;

        n_exam = 1'b0; n_park = 1'b0; n_commit = 1'b0;
        if (m_commit)                  ;
        else if (m_park)               begin if (vb && !m_cb) n_commit = 1'b1; else n_park = 1'b1; end
        else if (is_flush)             n_park = 1'b1;
        else if (do_pop)               n_exam = 1'b1;

        if (!vb) m_cb = 1'b0;
        else if (m_commit) m_cb = 1'b1;

        if (bus.chipselect && bus.write && bus.address == 2'd1) begin
            if (bus.writedata[0]) m_irq = 1'b0;
            if (bus.writedata[1]) m_ovf = 1'b0;
        end
        if (m_commit) begin
            m_front  = ~m_front;
            m_frames = m_frames + 16'd1;
            m_irq    = 1'b1;
        end

        if (do_pop) begin
            m_word = m_q[0];
            m_q.pop_front();
        end
        if (bus.chipselect && bus.write && bus.address == 2'd0) begin
            if (lvl == DEPTH) m_ovf = 1'b1;
            else              m_q.push_back(bus.writedata);
        end
        m_exam = n_exam; m_park = n_park; m_commit = n_commit;
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) model_reset();
        else        model_step();
    end

    // ---------------- checking ----------------
    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    initial forever begin
        @(negedge clk);
        if (reset === 1'b1) begin
            check_output("model_cmd_out", cmd_out, m_cmd);
            check_output("model_front_buf", 32'(front_buf), 32'(m_front));
            check_output("model_irq", 32'(irq), 32'(m_irq));
            check_output("model_readdata", bus.readdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_idle();
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = 2'd0; bus.writedata = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
        bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b0; bus.read = 1'b1;
        bus.address = a; bus.writedata = '0;
        @(negedge clk);
        d = bus.readdata;
        bus_idle();
    endtask

    task automatic wait_line(input int v);
        int n = 0;
        while (vcount != 10'(v) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (vcount != 10'(v)) begin
            n_vec++; n_err++;
            $display("[TB] FAIL wait_line: vcount %0d, required %0d", vcount, v);
        end
    endtask

    task automatic wait_cmd(input string name, input logic [31:0] exp, output int when);
        int n = 0;
        while (cmd_out !== exp && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check_output(name, cmd_out, exp);
        when = cyc;
    endtask

    task automatic apply_stimulus_random(input int cycles);
        int          op;
        int          sel;
        logic [31:0] w;
        for (int i = 0; i < cycles; i++) begin
            op = $urandom_range(0, 99);
            bus_idle();
            if (op < 50) begin
                sel = $urandom_range(0, 99);
                w   = $urandom;
                if (sel < 70)      w[20:17] = 4'h1;
                else if (sel < 75) w[20:17] = 4'hF;
                else if (sel < 85) w[20:17] = 4'h3;
                bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 2'd0; bus.writedata = w;
            end else if (op < 65) begin
                bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 2'($urandom_range(0, 3));
            end else if (op < 70) begin
                bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 2'd1;
                bus.writedata = 32'($urandom_range(0, 3));
            end
            @(negedge clk);
        end
        bus_idle();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] rd;
        int          t1, t2, issued, nz;
        logic        seen;

        bus_idle();
        repeat (3) @(negedge clk);
        check_output("reset_cmd_out", cmd_out, 32'h0);
        check_output("reset_front_buf", 32'(front_buf), 32'h0);
        check_output("reset_irq", 32'(irq), 32'h0);
        check_output("reset_readdata", bus.readdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Single sprite write: appears two edges after it is sampled, one cycle only
        bus_write(2'd0, 32'h0842_4155);
        check_output("lat_edge1", cmd_out, 32'h0);
        @(negedge clk);
        check_output("lat_edge2_pre", cmd_out, 32'h0);
        @(negedge clk);
        check_output("lat_issue", cmd_out, 32'h0842_6155);
        @(negedge clk);
        check_output("lat_one_cycle", cmd_out, 32'h0);

        // Three writes then a commit marker mid-frame
        wait_line(100);
        bus_write(2'd0, 32'h0002_0001);
        bus_write(2'd0, 32'h0002_0002);
        bus_write(2'd0, 32'h0002_0003);
        check_output("burst_w0", cmd_out, 32'h0002_2001);
        bus_write(2'd0, 32'h001E_0000);
        check_output("burst_w1", cmd_out, 32'h0002_2002);
        @(negedge clk);
        check_output("burst_w2", cmd_out, 32'h0002_2003);
        @(negedge clk);
        check_output("burst_marker_quiet", cmd_out, 32'h0);
        wait_cmd("commit_word", 32'h001E_2000, t1);
        check_output("commit_line", 32'(vcount), 32'd482);
        check_output("commit_front", 32'(front_buf), 32'h1);
        check_output("commit_irq", 32'(irq), 32'h1);
        bus_read(2'd1, rd);
        check_output("commit_frame_cnt", rd, 32'd1);

        // Two markers in one frame commit in two successive blanks
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_line(100);
        bus_write(2'd0, 32'h001E_0000);
        bus_write(2'd0, 32'h001E_0000);
        wait_cmd("double_c1", 32'h001E_2000, t1);
        @(negedge clk);
        wait_cmd("double_c2", 32'h001E_0000, t2);
        check_output("double_spacing", 32'(t2 - t1), 32'(FRAME));
        bus_read(2'd1, rd);
        check_output("double_frame_cnt", rd, 32'd2);

        // Overflow while stalled on a marker
        wait_line(10);
        bus_write(2'd0, 32'h001E_0000);
        for (int i = 0; i <= DEPTH; i++) bus_write(2'd0, 32'h0002_0000 | 32'(i));
        bus_read(2'd0, rd);
        check_output("ovf_status", rd, 32'hA000_0040);
        bus_write(2'd1, 32'h2);
        bus_read(2'd0, rd);
        check_output("ovf_cleared", rd, 32'h2000_0040);
        issued = 0;
        seen   = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (cmd_out[20:17] == 4'h1) issued++;
            if (cmd_out == 32'h0002_0040) seen = 1'b1;
        end
        check_output("ovf_issued", 32'(issued), 32'd64);
        check_output("ovf_dropped_word", 32'(seen), 32'h0);

        // Unknown info code is discarded, the next word follows immediately
        bus_write(2'd0, 32'h0006_0000);
        bus_write(2'd0, 32'h0002_0ABC);
        @(negedge clk);
        check_output("discard_quiet", cmd_out, 32'h0);
        @(negedge clk);
        check_output("discard_next", cmd_out, 32'h0002_0ABC);

        // Reset while parked on a marker with words queued
        wait_line(10);
        bus_write(2'd0, 32'h001E_0000);
        for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h0002_0100 | 32'(i));
        bus_read(2'd0, rd);
        check_output("park_status", rd, 32'h6000_0005);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_cmd_out", cmd_out, 32'h0);
        check_output("async_front_buf", 32'(front_buf), 32'h0);
        check_output("async_irq", 32'(irq), 32'h0);
        check_output("async_readdata", bus.readdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        bus_read(2'd0, rd);
        check_output("post_reset_status", rd, 32'h0);
        nz = 0;
        for (int i = 0; i < 2 * FRAME && vcount != 10'd500; i++) begin
            if (cmd_out !== 32'h0) nz++;
            @(negedge clk);
        end
        check_output("no_commit_words", 32'(nz), 32'h0);
        check_output("no_commit_front", 32'(front_buf), 32'h0);
        bus_read(2'd1, rd);
        check_output("no_commit_frames", rd, 32'h0);

        // Randomized traffic against the model
        apply_stimulus_random(3000);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
